// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, RV32I load/store
// funct3 codes, FSM state encoding, latched request payload and the
// alignment helper.
package lsu_pkg;

  localparam int unsigned LSU_BITS      = 32;
  localparam int unsigned LSU_WADDR_BITS = LSU_BITS - 2;

  localparam logic [2:0] LSU_F3_LB  = 3'b000;
  localparam logic [2:0] LSU_F3_LH  = 3'b001;
  localparam logic [2:0] LSU_F3_LW  = 3'b010;
  localparam logic [2:0] LSU_F3_LBU = 3'b100;
  localparam logic [2:0] LSU_F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } lsu_state_e;

  // Request captured on acceptance and held for the whole access.
  typedef struct packed {
    logic [2:0]          funct3;
    logic                we;
    logic [LSU_BITS-1:0] addr;
    logic [LSU_BITS-1:0] wdata;
  } lsu_req_t;

  // Access size is encoded in funct3[1:0]: 00 byte, 01 half, 1x word
  // (the reserved codes 011/110/111 fall into the word class).
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (f3[1]) begin
      mis = (a != 2'b00);
    end else if (f3[0]) begin
      mis = a[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the load/store unit.
// Extracts and sign/zero-extends sub-word load data from a memory word, and
// merges sub-word store data into a read word for read-modify-write.
// Built with LSU_SUBWORD_EN undefined it degenerates to word pass-through.
// Ports:
//   word    in  32  word read from data memory
//   addr    in  2   byte offset within the word
//   funct3  in  3   RV32I load/store funct3
//   sdata   in  32  store data (rs2)
//   ld_data out 32  extended load result
//   st_word out 32  word to write back to memory
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [LSU_BITS-1:0] word,
  input  logic [1:0]          addr,
  input  logic [2:0]          funct3,
  input  logic [LSU_BITS-1:0] sdata,
  output logic [LSU_BITS-1:0] ld_data,
  output logic [LSU_BITS-1:0] st_word
);

`ifdef LSU_SUBWORD_EN
  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes; funct3[2] selects zero extension.
  always_comb begin
    bit_off  = {addr, 3'b000};
    byte_sel = word[bit_off +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    ld_data  = word;
    st_word  = sdata;
    case (funct3[1:0])
      2'b00: begin
        ld_data = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
        st_word = word;
        st_word[bit_off +: 8] = sdata[7:0];
      end
      2'b01: begin
        ld_data = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
        st_word = addr[1] ? {sdata[15:0], word[15:0]} : {word[31:16], sdata[15:0]};
      end
      default: ;
    endcase
  end
`else
  logic unused_lane;
  assign unused_lane = ^{addr, funct3};
  assign ld_data     = word;
  assign st_word     = sdata;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit between the EX-stage ALU and a word-addressed, stalling
// data memory. Sub-word stores are done as read-modify-write because the
// memory has no byte enables.
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses, RMW stores,
// alignment checks). Without it every access is word sized.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/we/funct3   request from EX, held stable while stall=1
//   req_addr/req_wdata    effective address and store data
//   stall                 freeze pipeline during the access
//   done                  one-cycle completion pulse
//   rdata                 load result, held until the next done
//   misalign              one-cycle reject of a misaligned request
//   mem_cen/wen/addr/wdata  memory request (one strobe per access)
//   mem_rdata/mem_stall   memory response
module lsu
  import lsu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [LSU_BITS-1:0]       req_addr,
  input  logic [LSU_BITS-1:0]       req_wdata,
  output logic                      stall,
  output logic                      done,
  output logic [LSU_BITS-1:0]       rdata,
  output logic                      misalign,
  output logic                      mem_cen,
  output logic                      mem_wen,
  output logic [LSU_WADDR_BITS-1:0] mem_addr,
  output logic [LSU_BITS-1:0]       mem_wdata,
  input  logic [LSU_BITS-1:0]       mem_rdata,
  input  logic                      mem_stall
);

  lsu_state_e          state_q, state_d;
  lsu_req_t            req_q;
  logic [LSU_BITS-1:0] rdata_q;
  logic [LSU_BITS-1:0] ld_data;
  logic [LSU_BITS-1:0] st_word;
  logic                mis_c;
  logic                rmw_c;
  logic                accept_c;
  logic                cen_c;
  logic                wen_c;
  logic                done_c;

  // Misaligned requests are rejected in IDLE; sub-word stores need a read first.
`ifdef LSU_SUBWORD_EN
  assign mis_c = (state_q == ST_IDLE) & req_valid & is_misaligned(req_funct3, req_addr[1:0]);
  assign rmw_c = req_we & ~req_funct3[1];
`else
  assign mis_c = 1'b0;
  assign rmw_c = 1'b0;
`endif

  assign accept_c = (state_q == ST_IDLE) & req_valid & ~mis_c;

  lsu_lane u_lane (
    .word    (mem_rdata),
    .addr    (req_q.addr[1:0]),
    .funct3  (req_q.funct3),
    .sdata   (req_q.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    cen_c   = 1'b0;
    wen_c   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = (req_we && !rmw_c) ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        cen_c   = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (!mem_stall) begin
          state_d = req_q.we ? ST_WR_REQ : ST_RESP;
        end
      end
      ST_WR_REQ: begin
        cen_c   = 1'b1;
        wen_c   = 1'b1;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, RMW merge register and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        req_q <= '{funct3: req_funct3, we: req_we, addr: req_addr, wdata: req_wdata};
      end
      if ((state_q == ST_RD_WAIT) && !mem_stall) begin
        if (req_q.we) begin
          req_q.wdata <= st_word;
        end else begin
          rdata_q <= ld_data;
        end
      end
    end
  end

  // Every output is held at zero while reset is asserted.
  assign stall     = rst_n & req_valid & (state_q != ST_RESP) & ~mis_c;
  assign done      = rst_n & done_c;
  assign misalign  = rst_n & mis_c;
  assign mem_cen   = rst_n & cen_c;
  assign mem_wen   = rst_n & wen_c;
  assign mem_addr  = rst_n ? req_q.addr[LSU_BITS-1:2] : '0;
  assign mem_wdata = rst_n ? req_q.wdata : '0;
  assign rdata     = rst_n ? rdata_q : '0;

endmodule
